branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the maximum number of in-flight predictions (power of two, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-003 One clock and one asynchronous active-low reset; the port list SHALL be:
  clk  input  1  rising-edge clock for all state.
  rst_n  input  1  asynchronous active-low reset.
  pred_valid  input  1  predictor issued a prediction this cycle.
  pred_taken  input  1  predicted direction (1 = taken).
  pred_ready  output  1  an entry is free to accept a prediction.
  res_valid  input  1  execute stage resolved the oldest in-flight branch.
  res_taken  input  1  actual direction (1 = taken).
  res_ready  output  1  at least one prediction is in flight.
  upd_request  output  1  one-cycle pulse: predictor counter update.
  upd_result  output  1  actual outcome for the update.
  upd_taken  output  1  compare reference for the update; constant 1.
  mispredict  output  1  one-cycle pulse: resolved branch was mispredicted.
  total_cnt  output  CNT_W  resolved branches, saturating.
  miss_cnt  output  CNT_W  mispredicted branches, saturating.

Function
REQ-004 Predictions SHALL be held in a DEPTH-entry FIFO, oldest first; a push SHALL occur when pred_valid && pred_ready.
REQ-005 pred_ready SHALL be 1 when count < DEPTH and mispredict is 0; otherwise 0.
REQ-006 res_ready SHALL be 1 when count > 0; a pop SHALL occur when res_valid && res_ready.
REQ-007 res_valid while res_ready = 0 SHALL be ignored, with no output, counter or FIFO change.
REQ-008 A push and a pop in the same cycle SHALL leave count unchanged when the pop is a correct prediction.
REQ-009 On a pop, the block SHALL compare the head pred_taken with res_taken; an inequality is a mispredict.
REQ-010 One cycle after a pop, upd_request SHALL be 1, upd_result SHALL equal the popped res_taken and mispredict SHALL equal the comparison result; both pulses SHALL be 0 in all other cycles.
REQ-011 upd_result SHALL hold its last value when upd_request is 0.
REQ-012 On a mispredicting pop, all younger entries SHALL be discarded at that edge, including any push in the same cycle; count SHALL become 0 and the read/write pointers SHALL be reset.
REQ-013 total_cnt SHALL increment on every pop; miss_cnt SHALL increment on every mispredicting pop.
REQ-014 Both counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-015 Counter updates SHALL be visible in the same cycle as the corresponding upd_request pulse.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 pred_ready and res_ready SHALL be combinational from registered state only; they SHALL have no combinational path from pred_valid or res_valid.

Reset
REQ-018 While rst_n = 0, the FIFO SHALL be empty (count 0, pointers 0).
REQ-019 While rst_n = 0: pred_ready = 1, res_ready = 0, upd_request = 0, upd_result = 0, mispredict = 0, total_cnt = 0, miss_cnt = 0.
REQ-020 Reset assertion mid-operation SHALL discard all in-flight entries immediately.
REQ-021 The first push SHALL be accepted on the first rising clk edge after rst_n deasserts.

Structure
REQ-022 The package bp_pkg SHALL hold the DEPTH and CNT_W defaults and a saturating-increment function shared with predictor-side stats.
REQ-023 The FIFO SHALL be a sub-module bp_fifo (DEPTH x 1 bit, with push, pop, clear, count outputs).
REQ-024 Compare, pulse and counter logic SHALL reside in branch_resolver.

Verification
REQ-025 Fill to full: push taken, not-taken, taken, taken -> pred_ready = 0 after the 4th push; a 5th pred_valid is not stored.
REQ-026 Correct resolves: resolve four entries matching the predictions -> four upd_request pulses, mispredict always 0, total_cnt = 4, miss_cnt = 0, res_ready = 0 at end.
REQ-027 Mispredict flush: push T, N, T; resolve the head with res_taken = 0 -> mispredict = 1 next cycle, upd_result = 0, count = 0, miss_cnt = 1, pred_ready = 0 for that cycle.
REQ-028 Simultaneous push and pop: count = 2, correct pop plus push in one cycle -> count stays 2 and FIFO order is preserved; the same with a mispredicting pop -> count = 0.
REQ-029 Saturation: CNT_W = 2, 5 mispredicting resolves -> total_cnt = miss_cnt = 3.
REQ-030 Reset mid-stream: rst_n low with 3 entries in flight -> all outputs at reset values immediately, res_ready = 0, and no upd_request after release.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults and saturating increment for branch statistics
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_CNT_W = 16;

  // Generic over widths up to 32 so predictor-side stats can reuse it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// rtl/bp_fifo.sv - DEPTH x 1 bit in-flight prediction FIFO with synchronous clear
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Clear wins over a same-cycle push; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - resolves in-flight branch predictions, flushes on mispredict
module branch_resolver
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             upd_request,
  output logic             upd_result,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] count;
  logic        head;
  logic        push;
  logic        pop;
  logic        miss_now;

  // Readies depend only on registered count and mispredict.
  assign pred_ready = (count < (PW+1)'(DEPTH)) && !mispredict;
  assign res_ready  = (count != '0);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;
  assign miss_now   = pop && (head != res_taken);
  assign upd_taken  = 1'b1;

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pred_taken),
    .pop       (pop),
    .clear     (miss_now),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_request <= 1'b0;
      upd_result  <= 1'b0;
      mispredict  <= 1'b0;
      total_cnt   <= '0;
      miss_cnt    <= '0;
    end else begin
      upd_request <= pop;
      mispredict  <= miss_now;
      if (pop) begin
        upd_result <= res_taken;
        total_cnt  <= CNT_W'(sat_inc(32'(total_cnt), CNT_W));
      end
      if (miss_now) begin
        miss_cnt <= CNT_W'(sat_inc(32'(miss_cnt), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;

  logic        pred_ready, res_ready, upd_request, upd_result, upd_taken, mispredict;
  logic [15:0] total_cnt, miss_cnt;
  logic        s_pred_ready, s_res_ready, s_upd_request, s_upd_result, s_upd_taken, s_mispredict;
  logic [1:0]  s_total_cnt, s_miss_cnt;

  int checks   = 0;
  int failures = 0;

  logic m_q[$];
  int   m_total;
  int   m_misses;
  logic m_upd;
  logic m_miss;
  logic m_res;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_request(upd_request), .upd_result(upd_result), .upd_taken(upd_taken),
    .mispredict(mispredict), .total_cnt(total_cnt), .miss_cnt(miss_cnt)
  );

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(s_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(s_res_ready),
    .upd_request(s_upd_request), .upd_result(s_upd_result), .upd_taken(s_upd_taken),
    .mispredict(s_mispredict), .total_cnt(s_total_cnt), .miss_cnt(s_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_total  = 0;
    m_misses = 0;
    m_upd    = 1'b0;
    m_miss   = 1'b0;
    m_res    = 1'b0;
  endtask

  task automatic chk_post();
    chk("upd_request", 32'(upd_request), 32'(m_upd));
    chk("mispredict", 32'(mispredict), 32'(m_miss));
    chk("upd_result", 32'(upd_result), 32'(m_res));
    chk("upd_taken", 32'(upd_taken), 32'd1);
    chk("total_cnt", 32'(total_cnt), 32'(sat(m_total, 16)));
    chk("miss_cnt", 32'(miss_cnt), 32'(sat(m_misses, 16)));
    chk("sat_total_cnt", 32'(s_total_cnt), 32'(sat(m_total, 2)));
    chk("sat_miss_cnt", 32'(s_miss_cnt), 32'(sat(m_misses, 2)));
    chk("sat_mispredict", 32'(s_mispredict), 32'(m_miss));
  endtask

  // Called at a falling edge: apply inputs, check readies, cross one rising edge, check results.
  task automatic cycle(input logic pv, input logic pt, input logic rv, input logic rt,
                       output logic smp_pr, output logic smp_rr);
    logic epr, err, push, pop, miss;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    #1;
    epr = (m_q.size() < DEPTH) && !m_miss;
    err = (m_q.size() > 0);
    smp_pr = pred_ready;
    smp_rr = res_ready;
    chk("pred_ready", 32'(pred_ready), 32'(epr));
    chk("res_ready", 32'(res_ready), 32'(err));
    chk("sat_pred_ready", 32'(s_pred_ready), 32'(epr));
    push = pv && epr;
    pop  = rv && err;
    miss = 1'b0;
    if (pop) begin
      miss = (m_q[0] != rt);
      m_q.delete(0);
      m_total++;
      if (miss) m_misses++;
      m_res = rt;
    end
    if (miss) m_q.delete();
    else if (push) m_q.push_back(pt);
    m_upd  = pop;
    m_miss = miss;
    @(negedge clk);
    chk_post();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pred_ready", 32'(pred_ready), 32'd1);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_upd_request", 32'(upd_request), 32'd0);
    chk("rst_upd_result", 32'(upd_result), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_total_cnt", 32'(total_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_sat_total_cnt", 32'(s_total_cnt), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic pv, pt, rv, rt;
    logic pr, rr;
    logic ur, mp, res;
    int   tot, mis;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic spr, srr, head_v, rt_v;

    //           pv pt rv rt  pr rr  ur mp res tot mis
    tbl[0]  = '{1, 1, 0, 0,  1, 0,  0, 0, 0,  0, 0};
    tbl[1]  = '{1, 0, 0, 0,  1, 1,  0, 0, 0,  0, 0};
    tbl[2]  = '{1, 1, 0, 0,  1, 1,  0, 0, 0,  0, 0};
    tbl[3]  = '{1, 1, 0, 0,  1, 1,  0, 0, 0,  0, 0};
    tbl[4]  = '{1, 0, 0, 0,  0, 1,  0, 0, 0,  0, 0};
    tbl[5]  = '{0, 0, 1, 1,  0, 1,  1, 0, 1,  1, 0};
    tbl[6]  = '{0, 0, 1, 0,  1, 1,  1, 0, 0,  2, 0};
    tbl[7]  = '{0, 0, 1, 1,  1, 1,  1, 0, 1,  3, 0};
    tbl[8]  = '{0, 0, 1, 1,  1, 1,  1, 0, 1,  4, 0};
    tbl[9]  = '{0, 0, 1, 0,  1, 0,  0, 0, 1,  4, 0};
    tbl[10] = '{1, 1, 0, 0,  1, 0,  0, 0, 1,  4, 0};
    tbl[11] = '{1, 0, 0, 0,  1, 1,  0, 0, 1,  4, 0};
    tbl[12] = '{1, 1, 0, 0,  1, 1,  0, 0, 1,  4, 0};
    tbl[13] = '{0, 0, 1, 0,  1, 1,  1, 1, 0,  5, 1};
    tbl[14] = '{1, 1, 1, 1,  0, 0,  0, 0, 0,  5, 1};
    tbl[15] = '{1, 1, 0, 0,  1, 0,  0, 0, 0,  5, 1};
    tbl[16] = '{1, 0, 0, 0,  1, 1,  0, 0, 0,  5, 1};
    tbl[17] = '{1, 1, 1, 1,  1, 1,  1, 0, 1,  6, 1};
    tbl[18] = '{0, 0, 1, 0,  1, 1,  1, 0, 0,  7, 1};
    tbl[19] = '{1, 0, 0, 0,  1, 1,  0, 0, 0,  7, 1};
    tbl[20] = '{1, 1, 1, 0,  1, 1,  1, 1, 0,  8, 2};
    tbl[21] = '{0, 0, 1, 0,  0, 0,  0, 0, 0,  8, 2};

    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // Fill, drain, flush and simultaneous push/pop vectors.
    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rt, spr, srr);
      chk($sformatf("vec%0d_pred_ready", i), 32'(spr), 32'(tbl[i].pr));
      chk($sformatf("vec%0d_res_ready", i), 32'(srr), 32'(tbl[i].rr));
      chk($sformatf("vec%0d_upd_request", i), 32'(upd_request), 32'(tbl[i].ur));
      chk($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].mp));
      chk($sformatf("vec%0d_upd_result", i), 32'(upd_result), 32'(tbl[i].res));
      chk($sformatf("vec%0d_total_cnt", i), 32'(total_cnt), 32'(tbl[i].tot));
      chk($sformatf("vec%0d_miss_cnt", i), 32'(miss_cnt), 32'(tbl[i].mis));
    end

    // Saturation on the 2-bit instance: five mispredicting resolves.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, spr, srr);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, spr, srr);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, spr, srr);
    end
    chk("saturated_total", 32'(s_total_cnt), 32'd3);
    chk("saturated_miss", 32'(s_miss_cnt), 32'd3);
    chk("wide_total", 32'(total_cnt), 32'd5);
    chk("wide_miss", 32'(miss_cnt), 32'd5);

    // Reset asserted with three entries in flight and an update pulse active.
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, spr, srr);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, spr, srr);
    chk("pre_reset_upd_request", 32'(upd_request), 32'd1);
    res_valid = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, spr, srr);
      chk("post_reset_no_upd", 32'(upd_request), 32'd0);
      chk("post_reset_res_ready", 32'(srr), 32'd0);
    end

    // Randomized traffic against the queue model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      head_v = (m_q.size() > 0) ? m_q[0] : 1'($urandom_range(0, 1));
      rt_v   = ($urandom_range(0, 3) == 0) ? ~head_v : head_v;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), rt_v, spr, srr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
